uart_byte_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) that turns the board's UART RX pin into a byte stream with a single-cycle valid strobe. It sits directly upstream of the "hello" sequence checker and drives its `data_in` / `data_in_valid` inputs. It also flags malformed frames so higher layers can count line errors.

---
 rtl/uart_byte_rx.sv | 133 +++++++++++++
 tb/tb_uart_byte_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first: two-flop input sync, mid-bit sampling, one-cycle
// data_out_valid / frame_err strobes. A low stop bit parks in BREAK until the line idles.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       frame_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  // state | meaning
  // IDLE  | line idle, waiting for a low rx_s
  // START | half a bit into the start bit, confirm it is still low
  // DATA  | sampling the 8 data bits at mid-bit
  // STOP  | sampling the stop bit at mid-bit
  // BREAK | stop bit was low, wait for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_s_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_err      = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed + randomized bench for uart_byte_rx: a bit-level UART transmitter with
// baud skew, a strobe monitor, and an expected-byte queue built from the frames sent.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 4_608_000;
  localparam int BAUD     = 115_200;
  localparam int BD       = CLK_FREQ / BAUD;
  localparam int HALF     = BD / 2;
  localparam int LAT      = 4 + HALF + 9 * BD;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_err;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .uart_rx        (uart_rx),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .frame_err      (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  int          n_err    = 0;
  int          viol     = 0;
  bit          mon_en   = 0;
  logic [7:0]  prev_data;
  logic        prev_v   = 1'b0;
  logic        prev_e   = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitor: records every event and flags protocol violations.
  always @(negedge sys_clk) begin
    if (data_out_valid === 1'b1) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
    if (frame_err === 1'b1) n_err++;
    if (mon_en) begin
      if (data_out_valid && frame_err) viol++;
      if (data_out_valid && prev_v) viol++;
      if (frame_err && prev_e) viol++;
      if ((data_out !== prev_data) && !data_out_valid) viol++;
    end
    prev_v    = data_out_valid;
    prev_e    = frame_err;
    prev_data = data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    got_t.delete();
    n_err = 0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  // Bit edges at round(k*period) so fractional skew accumulates across the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real period);
    logic [9:0] bits;
    int dur;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      dur = $rtoi((i + 1) * period + 0.5) - $rtoi(i * period + 0.5);
      repeat (dur) @(negedge sys_clk);
    end
  endtask

  initial begin
    logic [7:0]  hello[5];
    logic [7:0]  exp_q[$];
    logic [7:0]  last;
    logic [7:0]  b;
    int          exp_err;
    int unsigned t0;
    int unsigned lat;
    bit          bad;
    real         factor;

    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    idle(4);
    mon_en = 1;

    // Single byte with latency
    clear_log();
    t0 = cyc;
    send_frame(8'h68, 1'b1, real'(BD));
    idle(2 * BD);
    check("single_count", got_q.size(), 1);
    check("single_ferr", n_err, 0);
    if (got_q.size() > 0) begin
      check("single_data", got_q[0], 8'h68);
      lat = got_t[0] - t0;
      n_checks++;
      assert ((lat + 1 >= LAT) && (lat <= LAT + 1)) else begin
        n_fail++;
        $error("FAIL single_latency: observed %0d expected %0d +/-1", lat, LAT);
      end
    end

    // Back-to-back "hello"
    clear_log();
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, real'(BD));
    idle(2 * BD);
    check("hello_count", got_q.size(), 5);
    check("hello_ferr", n_err, 0);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("hello_data", got_q[i], hello[i]);

    // Glitch shorter than half a bit
    clear_log();
    uart_rx = 1'b0;
    repeat (HALF / 2) @(negedge sys_clk);
    idle(2 * BD);
    check("glitch_no_strobe", got_q.size() + n_err, 0);
    send_frame(8'h55, 1'b1, real'(BD));
    idle(2 * BD);
    check("glitch_next_count", got_q.size(), 1);
    check("glitch_next_data", data_out, 8'h55);

    // Framing error followed by long break
    clear_log();
    send_frame(8'hA5, 1'b0, real'(BD));
    uart_rx = 1'b0;
    repeat (20000) @(negedge sys_clk);
    idle(2 * BD);
    check("break_ferr_count", n_err, 1);
    check("break_valid_count", got_q.size(), 0);
    check("break_data_hold", data_out, 8'h55);
    send_frame(8'h3C, 1'b1, real'(BD));
    idle(2 * BD);
    check("after_break_count", got_q.size(), 1);
    check("after_break_data", data_out, 8'h3C);

    // Reset during data bit 4
    clear_log();
    mon_en = 0;
    fork
      send_frame(8'hFF, 1'b1, real'(BD));
      begin
        repeat (5 * BD + BD / 2) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
      end
    join
    idle(2 * BD);
    mon_en = 1;
    check("midreset_no_strobe", got_q.size() + n_err, 0);
    check("midreset_data", data_out, 8'h00);
    send_frame(8'h81, 1'b1, real'(BD));
    idle(2 * BD);
    check("after_reset_count", got_q.size(), 1);
    check("after_reset_data", data_out, 8'h81);

    // Baud skew +3% / -3%
    clear_log();
    send_frame(8'h96, 1'b1, BD / 1.03);
    send_frame(8'h69, 1'b1, BD / 0.97);
    idle(2 * BD);
    check("skew_count", got_q.size(), 2);
    check("skew_ferr", n_err, 0);
    if (got_q.size() == 2) begin
      check("skew_fast_data", got_q[0], 8'h96);
      check("skew_slow_data", got_q[1], 8'h69);
    end

    // Randomized frames with skew, gaps and occasional bad stop bits
    clear_log();
    exp_err = 0;
    last    = 8'h69;
    for (int i = 0; i < 20; i++) begin
      b      = 8'($urandom_range(0, 255));
      bad    = ($urandom_range(0, 5) == 0);
      factor = 1.0 + (real'($urandom_range(0, 60)) - 30.0) / 1000.0;
      send_frame(b, !bad, BD / factor);
      if (bad) exp_err++;
      else begin
        exp_q.push_back(b);
        last = b;
      end
      idle($urandom_range(4, BD));
    end
    idle(2 * BD);
    check("rand_count", got_q.size(), exp_q.size());
    check("rand_ferr", n_err, exp_err);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rand_data", got_q[i], exp_q[i]);
    check("rand_last_data", data_out, last);

    check("strobe_protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
